// File: rtl/core_seq_pkg.sv
// Shared types and default sizing for the core accumulate-chain sequencer.
package core_seq_pkg;

    localparam int DEF_NCORE     = 8;
    localparam int DEF_MAT_WORDS = 64;
    localparam int MAX_LEN       = 128;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_INIT,
        S_EXEC,
        S_DRAIN,
        S_UPDATE,
        S_OUT
    } state_t;

endpackage

// File: rtl/core_seq.sv
// Job sequencer: matrix load, init, exec stream, drain and result readout
// across a chain of NCORE cores.
module core_seq
    import core_seq_pkg::*;
#(
    parameter int NCORE     = DEF_NCORE,
    parameter int MAT_WORDS = DEF_MAT_WORDS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             load_en,
    input  logic [7:0]       len,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [63:0]      ld_data,
    input  logic             src_valid,
    output logic             src_ready,
    input  logic [31:0]      src_data,
    output logic [NCORE-1:0] mat_v,
    output logic [5:0]       mat_a,
    output logic [64:0]      mat_d,
    output logic             init,
    output logic             exec,
    output logic             update,
    output logic             out_period,
    output logic [6:0]       exec_mat_addr,
    output logic [31:0]      exec_src_data,
    input  logic [31:0]      acc_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int CW = (NCORE > 1) ? $clog2(NCORE) : 1;

    state_t        state;
    state_t        nxt;
    logic [7:0]    len_q;
    logic [6:0]    k_q;
    logic [5:0]    word_q;
    logic [CW-1:0] core_q;
    logic [CW-1:0] oc_q;
    logic          drain_q;

    logic len_ok;
    logic ld_fire;
    logic src_fire;
    logic load_last;
    logic word_last;
    logic exec_last;
    logic out_last;

    assign len_ok    = (len != 8'd0) && (len <= 8'(MAX_LEN));
    assign ld_fire   = (state == S_LOAD) && ld_valid;
    assign src_fire  = (state == S_EXEC) && src_valid;
    assign word_last = (word_q == 6'(MAT_WORDS - 1));
    assign load_last = word_last && (core_q == CW'(NCORE - 1));
    assign exec_last = ({1'b0, k_q} == (len_q - 8'd1));
    assign out_last  = (oc_q == CW'(NCORE - 2));
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE:   if (start && len_ok) nxt = load_en ? S_LOAD : S_INIT;
            S_LOAD:   if (ld_fire && load_last) nxt = S_INIT;
            S_INIT:   nxt = S_EXEC;
            S_EXEC:   if (src_fire && exec_last) nxt = S_DRAIN;
            S_DRAIN:  if (drain_q) nxt = S_UPDATE;
            S_UPDATE: if (res_ready) nxt = (NCORE == 1) ? S_IDLE : S_OUT;
            S_OUT:    if (res_ready && out_last) nxt = S_IDLE;
            default:  nxt = S_IDLE;
        endcase
    end

    // Counters are only meaningful inside one job, so IDLE clears them all.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q   <= '0;
            k_q     <= '0;
            word_q  <= '0;
            core_q  <= '0;
            oc_q    <= '0;
            drain_q <= 1'b0;
        end else if (state == S_IDLE) begin
            k_q     <= '0;
            word_q  <= '0;
            core_q  <= '0;
            oc_q    <= '0;
            drain_q <= 1'b0;
            if (start && len_ok) len_q <= len;
        end else begin
            if (ld_fire) begin
                word_q <= word_last ? 6'd0 : word_q + 6'd1;
                if (word_last) core_q <= core_q + CW'(1);
            end
            if (src_fire) k_q <= k_q + 7'd1;
            if (state == S_DRAIN) drain_q <= ~drain_q;
            if (state == S_OUT && res_ready) oc_q <= oc_q + CW'(1);
        end
    end

    always_comb begin
        ld_ready      = 1'b0;
        src_ready     = 1'b0;
        mat_v         = '0;
        mat_a         = '0;
        mat_d         = '0;
        init          = 1'b0;
        exec          = 1'b0;
        update        = 1'b0;
        out_period    = 1'b0;
        exec_mat_addr = '0;
        exec_src_data = '0;
        res_valid     = 1'b0;
        res_data      = '0;
        done          = 1'b0;
        err           = 1'b0;
        unique case (state)
            S_IDLE: err = start && !len_ok && !rst;
            S_LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    mat_v = NCORE'(1) << core_q;
                    mat_a = word_q;
                    mat_d = {1'b0, ld_data};
                end
            end
            S_INIT: init = 1'b1;
            S_EXEC: begin
                src_ready = 1'b1;
                if (src_valid) begin
                    exec          = 1'b1;
                    exec_mat_addr = k_q;
                    exec_src_data = src_data;
                end
            end
            S_UPDATE: begin
                res_data = acc_in;
                if (res_ready) begin
                    update     = 1'b1;
                    out_period = 1'b1;
                    res_valid  = 1'b1;
                    done       = (NCORE == 1);
                end
            end
            S_OUT: begin
                res_data   = acc_in;
                out_period = res_ready;
                res_valid  = res_ready;
                done       = res_ready && out_last;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_core_seq.sv
// Directed bench for core_seq: vector table for an exec/result job plus
// hand sequences for full load, reset mid-load and follow-on jobs.
module tb_core_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        load_en;
    logic [7:0]  len;
    logic        ld_valid;
    logic        ld_ready;
    logic [63:0] ld_data;
    logic        src_valid;
    logic        src_ready;
    logic [31:0] src_data;
    logic [7:0]  mat_v;
    logic [5:0]  mat_a;
    logic [64:0] mat_d;
    logic        init;
    logic        exec;
    logic        update;
    logic        out_period;
    logic [6:0]  exec_mat_addr;
    logic [31:0] exec_src_data;
    logic [31:0] acc_in;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    core_seq dut (
        .clk(clk), .rst(rst), .start(start), .load_en(load_en), .len(len),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .mat_v(mat_v), .mat_a(mat_a), .mat_d(mat_d),
        .init(init), .exec(exec), .update(update), .out_period(out_period),
        .exec_mat_addr(exec_mat_addr), .exec_src_data(exec_src_data),
        .acc_in(acc_in), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        st;
        logic        le;
        logic [7:0]  ln;
        logic        sv;
        logic [31:0] sd;
        logic        rr;
        logic [31:0] acc;
        logic [88:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [88:0] pk(
        input logic b, input logic i, input logic e,
        input logic [6:0] ea, input logic [31:0] ed,
        input logic u, input logic o, input logic r,
        input logic [31:0] rd, input logic d, input logic er,
        input logic sr, input logic lr, input logic [7:0] mv);
        return {b, i, e, ea, ed, u, o, r, rd, d, er, sr, lr, mv};
    endfunction

    function automatic logic [88:0] act();
        return pk(busy, init, exec, exec_mat_addr, exec_src_data,
                  update, out_period, res_valid, res_data, done, err,
                  src_ready, ld_ready, mat_v);
    endfunction

    function automatic vec_t v(
        input logic st, input logic le, input logic [7:0] ln,
        input logic sv, input logic [31:0] sd, input logic rr,
        input logic [31:0] acc, input logic [88:0] exp);
        vec_t t;
        t.st = st; t.le = le; t.ln = ln; t.sv = sv; t.sd = sd;
        t.rr = rr; t.acc = acc; t.exp = exp;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [127:0] a,
                       input logic [127:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        start = 0; load_en = 0; len = 0; ld_valid = 0; ld_data = 0;
        src_valid = 0; src_data = 0; res_ready = 0; acc_in = 0;
    endtask

    // Starts in the INIT cycle (posedge+1); ends at posedge+1 back in IDLE.
    task automatic run_tail(input int n, input int base, input string nm);
        idle_in();
        @(negedge clk);
        chk({nm, "_init"}, act(), pk(1,1,0,0,0,0,0,0,0,0,0,0,0,0));
        step();
        for (int k = 0; k < n; k++) begin
            src_valid = 1;
            src_data = 32'hC000_0000 + 32'(k);
            @(negedge clk);
            chk({nm, "_exec"}, act(),
                pk(1,0,1,7'(k),32'hC000_0000 + 32'(k),0,0,0,0,0,0,1,0,0));
            step();
        end
        src_valid = 0;
        src_data = 0;
        for (int d = 0; d < 2; d++) begin
            @(negedge clk);
            chk({nm, "_drain"}, act(), pk(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
            step();
        end
        res_ready = 1;
        for (int b = 0; b < 8; b++) begin
            acc_in = 32'(base + b);
            @(negedge clk);
            chk({nm, "_res"}, act(),
                pk(1,0,0,0,0,(b == 0),1,1,32'(base + b),(b == 7),0,0,0,0));
            step();
        end
        idle_in();
        @(negedge clk);
        chk({nm, "_idle"}, act(), pk(0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        step();
    endtask

    int n_upd;
    int n_op;
    int n_done;
    logic [63:0] d64;

    initial begin
        // exec/result job with stalls, len=0 reject and ignored starts
        tbl.push_back(v(1,0,8'd0,0,0,0,0, pk(0,0,0,0,0,0,0,0,0,0,1,0,0,0)));
        tbl.push_back(v(0,0,8'd0,0,0,0,0, pk(0,0,0,0,0,0,0,0,0,0,0,0,0,0)));
        tbl.push_back(v(1,0,8'd3,0,0,0,0, pk(0,0,0,0,0,0,0,0,0,0,0,0,0,0)));
        tbl.push_back(v(0,0,8'd0,0,0,0,0, pk(1,1,0,0,0,0,0,0,0,0,0,0,0,0)));
        tbl.push_back(v(0,0,8'd0,1,32'hA0,0,0,
                        pk(1,0,1,7'd0,32'hA0,0,0,0,0,0,0,1,0,0)));
        tbl.push_back(v(1,0,8'd0,0,0,0,0, pk(1,0,0,0,0,0,0,0,0,0,0,1,0,0)));
        tbl.push_back(v(0,0,8'd0,1,32'hA1,0,0,
                        pk(1,0,1,7'd1,32'hA1,0,0,0,0,0,0,1,0,0)));
        tbl.push_back(v(1,0,8'd5,0,0,0,0, pk(1,0,0,0,0,0,0,0,0,0,0,1,0,0)));
        tbl.push_back(v(0,0,8'd0,1,32'hA2,0,0,
                        pk(1,0,1,7'd2,32'hA2,0,0,0,0,0,0,1,0,0)));
        tbl.push_back(v(0,0,8'd0,0,0,0,0, pk(1,0,0,0,0,0,0,0,0,0,0,0,0,0)));
        tbl.push_back(v(0,0,8'd0,0,0,0,0, pk(1,0,0,0,0,0,0,0,0,0,0,0,0,0)));
        tbl.push_back(v(0,0,8'd0,0,0,0,0, pk(1,0,0,0,0,0,0,0,0,0,0,0,0,0)));
        tbl.push_back(v(0,0,8'd0,0,0,1,100,
                        pk(1,0,0,0,0,1,1,1,100,0,0,0,0,0)));
        tbl.push_back(v(0,0,8'd0,0,0,1,101, pk(1,0,0,0,0,0,1,1,101,0,0,0,0,0)));
        tbl.push_back(v(0,0,8'd0,0,0,1,102, pk(1,0,0,0,0,0,1,1,102,0,0,0,0,0)));
        tbl.push_back(v(0,0,8'd0,0,0,0,0, pk(1,0,0,0,0,0,0,0,0,0,0,0,0,0)));
        tbl.push_back(v(0,0,8'd0,0,0,0,0, pk(1,0,0,0,0,0,0,0,0,0,0,0,0,0)));
        tbl.push_back(v(0,0,8'd0,0,0,0,0, pk(1,0,0,0,0,0,0,0,0,0,0,0,0,0)));
        tbl.push_back(v(0,0,8'd0,0,0,1,103, pk(1,0,0,0,0,0,1,1,103,0,0,0,0,0)));
        tbl.push_back(v(0,0,8'd0,0,0,1,104, pk(1,0,0,0,0,0,1,1,104,0,0,0,0,0)));
        tbl.push_back(v(0,0,8'd0,0,0,1,105, pk(1,0,0,0,0,0,1,1,105,0,0,0,0,0)));
        tbl.push_back(v(0,0,8'd0,0,0,1,106, pk(1,0,0,0,0,0,1,1,106,0,0,0,0,0)));
        tbl.push_back(v(0,0,8'd0,0,0,1,107, pk(1,0,0,0,0,0,1,1,107,1,0,0,0,0)));
        tbl.push_back(v(0,0,8'd0,0,0,0,0, pk(0,0,0,0,0,0,0,0,0,0,0,0,0,0)));

        idle_in();
        rst = 1;
        step();
        step();
        @(negedge clk);
        chk("reset_hold", {act(), mat_a, mat_d}, '0);
        step();
        rst = 0;
        @(negedge clk);
        chk("reset_release", {act(), mat_a, mat_d}, '0);
        step();

        n_upd = 0;
        n_op = 0;
        n_done = 0;
        foreach (tbl[i]) begin
            start = tbl[i].st; load_en = tbl[i].le; len = tbl[i].ln;
            src_valid = tbl[i].sv; src_data = tbl[i].sd;
            res_ready = tbl[i].rr; acc_in = tbl[i].acc;
            @(negedge clk);
            chk($sformatf("row%0d", i), act(), tbl[i].exp);
            n_upd += int'(update);
            n_op += int'(out_period);
            n_done += int'(done);
            step();
        end
        chk("update_count", 128'(n_upd), 128'(1));
        chk("out_period_count", 128'(n_op), 128'(8));
        chk("done_count", 128'(n_done), 128'(1));

        // full matrix load, one stalled cycle, then a len=4 job
        idle_in();
        start = 1; load_en = 1; len = 8'd4;
        @(negedge clk);
        chk("load_start", act(), pk(0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        step();
        idle_in();
        for (int i = 0; i < 512; i++) begin
            if (i == 5) begin
                ld_valid = 0;
                @(negedge clk);
                chk("load_stall", {ld_ready, mat_v, busy}, {1'b1, 8'h00, 1'b1});
                step();
            end
            d64 = {32'(i), ~32'(i)};
            ld_valid = 1;
            ld_data = d64;
            @(negedge clk);
            chk($sformatf("load_beat%0d", i), {ld_ready, mat_v, mat_a, mat_d},
                {1'b1, 8'(1) << (i / 64), 6'(i % 64), 1'b0, d64});
            step();
        end
        run_tail(4, 200, "jobA");

        // reset asserted during the 100th load beat
        idle_in();
        start = 1; load_en = 1; len = 8'd2;
        step();
        idle_in();
        for (int i = 0; i < 100; i++) begin
            ld_valid = 1;
            ld_data = 64'(i);
            if (i == 99) begin
                rst = 1;
                #1;
                chk("rst_async", {busy, ld_ready, mat_v}, '0);
            end
            step();
        end
        rst = 0;
        idle_in();
        @(negedge clk);
        chk("rst_idle", {act(), mat_a, mat_d}, '0);
        step();

        start = 1; load_en = 0; len = 8'd1;
        @(negedge clk);
        chk("jobB_start", act(), pk(0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        step();
        run_tail(1, 300, "jobB");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
